// File: rtl/id_stage_reg_pkg.sv
// id_stage_reg_pkg: ALU command encodings and the control bundle shared by the decoder and the ID/EX register.
package id_stage_reg_pkg;
    localparam int EXE_CMD_W = 4;
    localparam logic [EXE_CMD_W-1:0] EXE_NOP = 4'b0000;
    localparam logic [EXE_CMD_W-1:0] EXE_MOV = 4'b0001;
    localparam logic [EXE_CMD_W-1:0] EXE_ADD = 4'b0010;
    localparam logic [EXE_CMD_W-1:0] EXE_ADC = 4'b0011;
    localparam logic [EXE_CMD_W-1:0] EXE_SUB = 4'b0100;
    localparam logic [EXE_CMD_W-1:0] EXE_SBC = 4'b0101;
    localparam logic [EXE_CMD_W-1:0] EXE_AND = 4'b0110;
    localparam logic [EXE_CMD_W-1:0] EXE_ORR = 4'b0111;
    localparam logic [EXE_CMD_W-1:0] EXE_EOR = 4'b1000;
    localparam logic [EXE_CMD_W-1:0] EXE_MVN = 4'b1001;

    typedef struct packed {
        logic                 wb_en;
        logic                 mem_r_en;
        logic                 mem_w_en;
        logic                 b;
        logic                 s;
        logic [EXE_CMD_W-1:0] exe_cmd;
    } ctrl_t;
endpackage

// File: rtl/id_stage_reg_sat_counter.sv
// sat_counter: synchronous-clear counter that holds on request and saturates at all-ones.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             hold,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);
    localparam logic [CNT_W-1:0] ONE = 1;
    logic [CNT_W-1:0] r_cnt;
    always_ff @(posedge clk) begin
        if (clr)
            r_cnt <= '0;
        else if (!hold && inc && r_cnt != '1)
            r_cnt <= r_cnt + ONE;
    end
    assign cnt = r_cnt;
endmodule

// File: rtl/id_stage_reg.sv
// id_stage_reg: ID->EX pipeline register; condition-failed instructions become bubbles with data kept,
// supports freeze and flush, and counts squashed instructions.
module id_stage_reg
    import id_stage_reg_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 4,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  freeze,
    input  logic                  cond_ok,
    input  logic                  id_valid,
    input  logic                  wb_en_in,
    input  logic                  mem_r_en_in,
    input  logic                  mem_w_en_in,
    input  logic                  b_in,
    input  logic                  s_in,
    input  logic [EXE_CMD_W-1:0]  exe_cmd_in,
    input  logic [DATA_W-1:0]     pc_in,
    input  logic [DATA_W-1:0]     val_rn_in,
    input  logic [DATA_W-1:0]     val_rm_in,
    input  logic                  imm_in,
    input  logic [11:0]           shift_op_in,
    input  logic [23:0]           simm24_in,
    input  logic [REG_ADDR_W-1:0] dest_in,
    input  logic [REG_ADDR_W-1:0] src1_in,
    input  logic [REG_ADDR_W-1:0] src2_in,
    input  logic                  carry_in,
    output logic                  wb_en_out,
    output logic                  mem_r_en_out,
    output logic                  mem_w_en_out,
    output logic                  b_out,
    output logic                  s_out,
    output logic [EXE_CMD_W-1:0]  exe_cmd_out,
    output logic [DATA_W-1:0]     pc_out,
    output logic [DATA_W-1:0]     val_rn_out,
    output logic [DATA_W-1:0]     val_rm_out,
    output logic                  imm_out,
    output logic [11:0]           shift_op_out,
    output logic [23:0]           simm24_out,
    output logic [REG_ADDR_W-1:0] dest_out,
    output logic [REG_ADDR_W-1:0] src1_out,
    output logic [REG_ADDR_W-1:0] src2_out,
    output logic                  carry_out,
    output logic                  ex_valid,
    output logic [CNT_W-1:0]      squash_cnt
);
    typedef struct packed {
        logic [DATA_W-1:0]     pc;
        logic [DATA_W-1:0]     val_rn;
        logic [DATA_W-1:0]     val_rm;
        logic                  imm;
        logic [11:0]           shift_op;
        logic [23:0]           simm24;
        logic [REG_ADDR_W-1:0] dest;
        logic [REG_ADDR_W-1:0] src1;
        logic [REG_ADDR_W-1:0] src2;
        logic                  carry;
    } data_t;

    ctrl_t r_ctrl;
    data_t r_data;
    logic  r_ex_valid;
    ctrl_t w_ctrl_in;
    data_t w_data_in;
    logic  w_live;

    assign w_live    = id_valid & cond_ok;
    assign w_ctrl_in = '{wb_en: wb_en_in, mem_r_en: mem_r_en_in, mem_w_en: mem_w_en_in,
                         b: b_in, s: s_in, exe_cmd: exe_cmd_in};
    assign w_data_in = '{pc: pc_in, val_rn: val_rn_in, val_rm: val_rm_in, imm: imm_in,
                         shift_op: shift_op_in, simm24: simm24_in, dest: dest_in,
                         src1: src1_in, src2: src2_in, carry: carry_in};

    // Flush zeroes data too; a condition-failed load keeps data for debug visibility.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_ctrl     <= '0;
            r_data     <= '0;
            r_ex_valid <= 1'b0;
        end else if (!freeze) begin
            r_ctrl     <= w_live ? w_ctrl_in : '0;
            r_data     <= w_data_in;
            r_ex_valid <= w_live;
        end
    end

    sat_counter #(.CNT_W(CNT_W)) u_squash (
        .clk  (clk),
        .clr  (rst),
        .hold (flush | freeze),
        .inc  (id_valid & ~cond_ok),
        .cnt  (squash_cnt)
    );

    assign wb_en_out    = r_ctrl.wb_en;
    assign mem_r_en_out = r_ctrl.mem_r_en;
    assign mem_w_en_out = r_ctrl.mem_w_en;
    assign b_out        = r_ctrl.b;
    assign s_out        = r_ctrl.s;
    assign exe_cmd_out  = r_ctrl.exe_cmd;
    assign pc_out       = r_data.pc;
    assign val_rn_out   = r_data.val_rn;
    assign val_rm_out   = r_data.val_rm;
    assign imm_out      = r_data.imm;
    assign shift_op_out = r_data.shift_op;
    assign simm24_out   = r_data.simm24;
    assign dest_out     = r_data.dest;
    assign src1_out     = r_data.src1;
    assign src2_out     = r_data.src2;
    assign carry_out    = r_data.carry;
    assign ex_valid     = r_ex_valid;
endmodule

// File: tb/tb_id_stage_reg.sv
// tb_id_stage_reg: directed vectors drive two instances (16-bit and 3-bit squash counters); expected
// outputs are queued per edge and a monitor pops and compares them after each rising edge.
module tb_id_stage_reg;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, flush, freeze, cond_ok, id_valid;
    logic        wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in, imm_in, carry_in;
    logic [3:0]  exe_cmd_in, dest_in, src1_in, src2_in;
    logic [31:0] pc_in, val_rn_in, val_rm_in;
    logic [11:0] shift_op_in;
    logic [23:0] simm24_in;

    logic        wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, imm_out, carry_out, ex_valid;
    logic [3:0]  exe_cmd_out, dest_out, src1_out, src2_out;
    logic [31:0] pc_out, val_rn_out, val_rm_out;
    logic [11:0] shift_op_out;
    logic [23:0] simm24_out;
    logic [15:0] squash_cnt;

    logic        s3_wb, s3_mr, s3_mw, s3_b, s3_s, s3_imm, s3_carry, s3_exv;
    logic [3:0]  s3_exe, s3_dest, s3_src1, s3_src2;
    logic [31:0] s3_pc, s3_rn, s3_rm;
    logic [11:0] s3_shift;
    logic [23:0] s3_simm;
    logic [2:0]  s3_cnt;

    id_stage_reg u_dut (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .cond_ok(cond_ok), .id_valid(id_valid),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .b_in(b_in),
        .s_in(s_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
        .val_rm_in(val_rm_in), .imm_in(imm_in), .shift_op_in(shift_op_in), .simm24_in(simm24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in),
        .wb_en_out(wb_en_out), .mem_r_en_out(mem_r_en_out), .mem_w_en_out(mem_w_en_out),
        .b_out(b_out), .s_out(s_out), .exe_cmd_out(exe_cmd_out), .pc_out(pc_out),
        .val_rn_out(val_rn_out), .val_rm_out(val_rm_out), .imm_out(imm_out),
        .shift_op_out(shift_op_out), .simm24_out(simm24_out), .dest_out(dest_out),
        .src1_out(src1_out), .src2_out(src2_out), .carry_out(carry_out), .ex_valid(ex_valid),
        .squash_cnt(squash_cnt)
    );

    id_stage_reg #(.CNT_W(3)) u_small (
        .clk(clk), .rst(rst), .flush(flush), .freeze(freeze), .cond_ok(cond_ok), .id_valid(id_valid),
        .wb_en_in(wb_en_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in), .b_in(b_in),
        .s_in(s_in), .exe_cmd_in(exe_cmd_in), .pc_in(pc_in), .val_rn_in(val_rn_in),
        .val_rm_in(val_rm_in), .imm_in(imm_in), .shift_op_in(shift_op_in), .simm24_in(simm24_in),
        .dest_in(dest_in), .src1_in(src1_in), .src2_in(src2_in), .carry_in(carry_in),
        .wb_en_out(s3_wb), .mem_r_en_out(s3_mr), .mem_w_en_out(s3_mw), .b_out(s3_b), .s_out(s3_s),
        .exe_cmd_out(s3_exe), .pc_out(s3_pc), .val_rn_out(s3_rn), .val_rm_out(s3_rm),
        .imm_out(s3_imm), .shift_op_out(s3_shift), .simm24_out(s3_simm), .dest_out(s3_dest),
        .src1_out(s3_src1), .src2_out(s3_src2), .carry_out(s3_carry), .ex_valid(s3_exv),
        .squash_cnt(s3_cnt)
    );

    typedef struct {
        logic [8:0]  ctrl;
        logic [31:0] pc;
        logic [31:0] rn;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic        exv;
        logic [15:0] sq;
        logic [2:0]  sq3;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("ctrl", {23'd0, wb_en_out, mem_r_en_out, mem_w_en_out, b_out, s_out, exe_cmd_out},
                {23'd0, e.ctrl});
            chk("pc", pc_out, e.pc);
            chk("val_rn", val_rn_out, e.rn);
            chk("dest", {28'd0, dest_out}, {28'd0, e.dest});
            chk("src1", {28'd0, src1_out}, {28'd0, e.src1});
            chk("ex_valid", {31'd0, ex_valid}, {31'd0, e.exv});
            chk("squash_cnt", {16'd0, squash_cnt}, {16'd0, e.sq});
            chk("squash_cnt3", {29'd0, s3_cnt}, {29'd0, e.sq3});
            chk("ex_valid3", {31'd0, s3_exv}, {31'd0, e.exv});
        end
    end

    // ctrl5 = {wb, mem_r, mem_w, b, s}; remaining inputs are derived so all-ones drives set every input.
    task automatic step(input logic r, fl, fz, iv, ok, input logic [4:0] c5, input logic [3:0] exe,
                        input logic [31:0] pc, rn, input logic [3:0] dst, s1,
                        input logic [4:0] e_c5, input logic [3:0] e_exe, input logic [31:0] e_pc, e_rn,
                        input logic [3:0] e_dst, e_s1, input logic e_exv, input logic [15:0] e_sq,
                        input logic [2:0] e_sq3);
        exp_t e;
        rst = r; flush = fl; freeze = fz; id_valid = iv; cond_ok = ok;
        {wb_en_in, mem_r_en_in, mem_w_en_in, b_in, s_in} = c5;
        exe_cmd_in = exe; pc_in = pc; val_rn_in = rn; val_rm_in = rn;
        dest_in = dst; src1_in = s1; src2_in = s1;
        imm_in = c5[0]; shift_op_in = {3{exe}}; simm24_in = pc[23:0]; carry_in = ok;
        e.ctrl = {e_c5, e_exe}; e.pc = e_pc; e.rn = e_rn; e.dest = e_dst; e.src1 = e_s1;
        e.exv = e_exv; e.sq = e_sq; e.sq3 = e_sq3;
        q.push_back(e);
        @(negedge clk);
    endtask

    initial begin
        repeat (2) step(1,1,1,1,1, 5'h1f, 4'hf, 32'hffffffff, 32'hffffffff, 4'hf, 4'hf,
                        5'h00, 4'h0, 32'h0, 32'h0, 4'h0, 4'h0, 1'b0, 16'd0, 3'd0);
        step(0,0,0,1,1, 5'b10000, 4'h2, 32'h0, 32'h1234, 4'd5, 4'd6,
             5'b10000, 4'h2, 32'h0, 32'h1234, 4'd5, 4'd6, 1'b1, 16'd0, 3'd0);
        step(0,0,0,1,0, 5'b10100, 4'h2, 32'h0, 32'h1234, 4'd5, 4'd6,
             5'b00000, 4'h0, 32'h0, 32'h1234, 4'd5, 4'd6, 1'b0, 16'd1, 3'd1);
        step(0,0,0,1,1, 5'b10000, 4'h2, 32'h40, 32'h1234, 4'd5, 4'd6,
             5'b10000, 4'h2, 32'h40, 32'h1234, 4'd5, 4'd6, 1'b1, 16'd1, 3'd1);
        step(0,0,1,1,1, 5'b00001, 4'h7, 32'h44, 32'haaaa, 4'd7, 4'd8,
             5'b10000, 4'h2, 32'h40, 32'h1234, 4'd5, 4'd6, 1'b1, 16'd1, 3'd1);
        step(0,0,1,1,0, 5'b10100, 4'h3, 32'h48, 32'hbbbb, 4'd9, 4'd10,
             5'b10000, 4'h2, 32'h40, 32'h1234, 4'd5, 4'd6, 1'b1, 16'd1, 3'd1);
        step(0,0,1,0,1, 5'b01000, 4'h1, 32'h4c, 32'hcccc, 4'd11, 4'd12,
             5'b10000, 4'h2, 32'h40, 32'h1234, 4'd5, 4'd6, 1'b1, 16'd1, 3'd1);
        step(0,1,1,1,0, 5'b11111, 4'hf, 32'h50, 32'hdddd, 4'd13, 4'd14,
             5'b00000, 4'h0, 32'h0, 32'h0, 4'd0, 4'd0, 1'b0, 16'd1, 3'd1);
        step(0,0,0,1,1, 5'b10001, 4'h4, 32'h54, 32'h5678, 4'd3, 4'd4,
             5'b10001, 4'h4, 32'h54, 32'h5678, 4'd3, 4'd4, 1'b1, 16'd1, 3'd1);
        for (int k = 1; k <= 10; k++)
            step(0,0,0,1,0, 5'b10000, 4'h2, 32'h100 + k, 32'(k), 4'd1, 4'd2,
                 5'b00000, 4'h0, 32'h100 + k, 32'(k), 4'd1, 4'd2, 1'b0, 16'(1 + k),
                 (k >= 6) ? 3'd7 : 3'(1 + k));
        step(0,0,0,0,0, 5'b10000, 4'h2, 32'h200, 32'heeee, 4'd2, 4'd3,
             5'b00000, 4'h0, 32'h200, 32'heeee, 4'd2, 4'd3, 1'b0, 16'd11, 3'd7);
        step(0,0,0,0,1, 5'b10000, 4'h2, 32'h204, 32'hffff, 4'd4, 4'd5,
             5'b00000, 4'h0, 32'h204, 32'hffff, 4'd4, 4'd5, 1'b0, 16'd11, 3'd7);
        step(0,0,1,1,0, 5'b10000, 4'h2, 32'h208, 32'h1111, 4'd6, 4'd7,
             5'b00000, 4'h0, 32'h204, 32'hffff, 4'd4, 4'd5, 1'b0, 16'd11, 3'd7);
        step(1,0,1,1,1, 5'b10000, 4'h2, 32'h20c, 32'h2222, 4'd8, 4'd9,
             5'b00000, 4'h0, 32'h0, 32'h0, 4'd0, 4'd0, 1'b0, 16'd0, 3'd0);
        step(0,0,0,1,1, 5'b00110, 4'h9, 32'h210, 32'h3333, 4'd10, 4'd11,
             5'b00110, 4'h9, 32'h210, 32'h3333, 4'd10, 4'd11, 1'b1, 16'd0, 3'd0);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
